// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending scoreboard for in-order issue.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rd_addr/rd_data   NRD combinational read ports (port k at [k*AW +: AW] / [k*XLEN +: XLEN])
//   issue_valid/_rs/_wr/_rd   decode issue request; stall flags a pending source hazard
//   wb_valid/_addr/_data      write-back, clears the pending bit of wb_addr
//   flush             clears every pending bit and blocks the same-cycle issue
//   pending/pending_cnt       scoreboard vector and its population count
// Macro REGFILE_WB_BYPASS_EN forwards write-back data to reads and resolves stalls in the same cycle.
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                issue_valid,
    input  logic [NRD*AW-1:0]   issue_rs,
    input  logic                issue_wr,
    input  logic [AW-1:0]       issue_rd,
    output logic                stall,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NREGS-1:0]    pending,
    output logic [AW:0]         pending_cnt
);
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [AW:0] NR = (AW+1)'(NREGS);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending_nxt;
    logic             wb_live, byp_ok, accept;

    // x0 and out-of-range addresses are neither stored nor tracked
    function automatic logic live(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NR);
    endfunction

    assign wb_live = wb_valid && live(wb_addr);
    assign byp_ok  = BYP && wb_live;
    assign accept  = issue_valid && !stall && !flush;

    // rd_data and stall are forced low while reset is held, independent of the array
    always_comb begin
        rd_data = '0;
        stall   = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            if (rst_n && live(rd_addr[k*AW +: AW]))
                rd_data[k*XLEN +: XLEN] = (byp_ok && rd_addr[k*AW +: AW] == wb_addr) ?
                                          wb_data : mem[rd_addr[k*AW +: AW]];
            if (rst_n && issue_valid && live(issue_rs[k*AW +: AW]) && pending[issue_rs[k*AW +: AW]] &&
                !(byp_ok && issue_rs[k*AW +: AW] == wb_addr))
                stall = 1'b1;
        end
    end

    // write-back clears before issue sets, so a same-register new producer stays pending
    always_comb begin
        pending_nxt = flush ? '0 : pending;
        if (wb_live)
            pending_nxt[wb_addr] = 1'b0;
        if (accept && issue_wr && live(issue_rd))
            pending_nxt[issue_rd] = 1'b1;
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NREGS; i++)
            pending_cnt = pending_cnt + {{AW{1'b0}}, pending[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else begin
            pending <= pending_nxt;
            if (wb_live)
                mem[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst_n;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic         issue_valid;
    logic [9:0]   issue_rs;
    logic         issue_wr;
    logic [4:0]   issue_rd;
    logic         stall;
    logic         wb_valid;
    logic [4:0]   wb_addr;
    logic [63:0]  wb_data;
    logic         flush;
    logic [31:0]  pending;
    logic [5:0]   pending_cnt;
    int           n_vec = 0;
    int           n_err = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .pending(pending), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        issue_valid = 0; issue_rs = '0; issue_wr = 0; issue_rd = '0;
        wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        rd_addr = {5'd5, 5'd5}; issue_valid = 1; issue_rs = {5'd5, 5'd5};
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stall); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL rst_rd got %h want 0", rd_data); end
        @(negedge clk); rst_n = 1; idle();
        #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL rel_rd got %h want 0", rd_data); end
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL rel_pend got %h want 0", pending); end
        n_vec++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL rel_cnt got %0d want 0", pending_cnt); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rel_stall got %b want 0", stall); end
    endtask

    task automatic test_hazard();
        @(negedge clk); idle();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd7;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL hz_first got %b want 0", stall); end
        step();
        issue_wr = 0; issue_rs = {5'd0, 5'd7}; rd_addr = {5'd0, 5'd7};
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL hz_stall got %b want 1", stall); end
        n_vec++; if (pending !== 32'h80) begin n_err++; $display("FAIL hz_pend got %h want 80", pending); end
        n_vec++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL hz_cnt got %0d want 1", pending_cnt); end
        step();
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL hz_hold got %b want 1", stall); end
        wb_valid = 1; wb_addr = 5'd7; wb_data = 64'h1234;
        #1;
        n_vec++; if (stall !== !BYP) begin n_err++; $display("FAIL hz_wbstall got %b want %b", stall, !BYP); end
        n_vec++; if (rd_data[63:0] !== (BYP ? 64'h1234 : 64'h0)) begin
            n_err++; $display("FAIL hz_wbrd got %h want %h", rd_data[63:0], BYP ? 64'h1234 : 64'h0); end
        step();
        wb_valid = 0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL hz_after got %b want 0", stall); end
        n_vec++; if (rd_data[63:0] !== 64'h1234) begin n_err++; $display("FAIL hz_rd got %h want 1234", rd_data[63:0]); end
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL hz_clr got %h want 0", pending); end
        idle();
    endtask

    task automatic test_x0();
        @(negedge clk); idle();
        wb_valid = 1; wb_addr = 5'd0; wb_data = 64'hFFFF;
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd0; issue_rs = '0; rd_addr = '0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got %b want 0", stall); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL x0_rdnow got %h want 0", rd_data); end
        step(); idle();
        issue_valid = 1; issue_rs = '0;
        #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL x0_rd got %h want 0", rd_data); end
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL x0_pend got %h want 0", pending); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_rs got %b want 0", stall); end
        idle();
    endtask

    task automatic test_same_cycle();
        @(negedge clk); idle();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd3;
        wb_valid = 1; wb_addr = 5'd3; wb_data = 64'hAA;
        step(); idle();
        rd_addr = {5'd3, 5'd3};
        #1;
        n_vec++; if (rd_data !== {64'hAA, 64'hAA}) begin n_err++; $display("FAIL sc_rd got %h want both AA", rd_data); end
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL sc_pend got %h want 8", pending); end
        n_vec++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL sc_cnt got %0d want 1", pending_cnt); end
        wb_valid = 1; wb_addr = 5'd3; wb_data = 64'hAA;
        step(); idle();
    endtask

    task automatic test_flush();
        @(negedge clk); idle();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd1; step();
        issue_rd = 5'd2; step();
        issue_rd = 5'd9; step();
        idle();
        #1;
        n_vec++; if (pending_cnt !== 6'd3) begin n_err++; $display("FAIL fl_cnt3 got %0d want 3", pending_cnt); end
        n_vec++; if (pending !== 32'h206) begin n_err++; $display("FAIL fl_pend3 got %h want 206", pending); end
        flush = 1; issue_valid = 1; issue_wr = 1; issue_rd = 5'd4;
        wb_valid = 1; wb_addr = 5'd9; wb_data = 64'h55;
        step(); idle();
        rd_addr = {5'd4, 5'd9};
        #1;
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL fl_pend got %h want 0", pending); end
        n_vec++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL fl_cnt got %0d want 0", pending_cnt); end
        n_vec++; if (rd_data[63:0] !== 64'h55) begin n_err++; $display("FAIL fl_x9 got %h want 55", rd_data[63:0]); end
        n_vec++; if (rd_data[127:64] !== 64'h0) begin n_err++; $display("FAIL fl_x4 got %h want 0", rd_data[127:64]); end
    endtask

    task automatic test_wb_not_pending();
        @(negedge clk); idle();
        rd_addr = {5'd0, 5'd12}; wb_valid = 1; wb_addr = 5'd12; wb_data = 64'hBEEF;
        #1;
        n_vec++; if (rd_data[63:0] !== (BYP ? 64'hBEEF : 64'h0)) begin
            n_err++; $display("FAIL np_now got %h want %h", rd_data[63:0], BYP ? 64'hBEEF : 64'h0); end
        step(); idle();
        #1;
        n_vec++; if (rd_data[63:0] !== 64'hBEEF) begin n_err++; $display("FAIL np_rd got %h want BEEF", rd_data[63:0]); end
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL np_pend got %h want 0", pending); end
    endtask

    task automatic test_reissue_async_reset();
        @(negedge clk); idle();
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd5; step(); step();
        #1;
        n_vec++; if (pending_cnt !== 6'd1) begin n_err++; $display("FAIL ri_cnt got %0d want 1", pending_cnt); end
        issue_rd = 5'd6; step();
        issue_rd = 5'd8; issue_rs = {5'd5, 5'd5};
        rd_addr = {5'd12, 5'd12}; wb_valid = 1; wb_addr = 5'd12; wb_data = 64'h77;
        #1;
        n_vec++; if (pending !== 32'h60) begin n_err++; $display("FAIL ar_pre got %h want 60", pending); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ar_prestall got %b want 1", stall); end
        #1 rst_n = 0;
        #1;
        n_vec++; if (pending !== '0) begin n_err++; $display("FAIL ar_pend got %h want 0", pending); end
        n_vec++; if (pending_cnt !== 6'd0) begin n_err++; $display("FAIL ar_cnt got %0d want 0", pending_cnt); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL ar_rd got %h want 0", rd_data); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ar_stall got %b want 0", stall); end
        @(negedge clk); idle(); rst_n = 1;
        #1;
        n_vec++; if (rd_data[63:0] !== 64'h0) begin n_err++; $display("FAIL ar_x12 got %h want 0", rd_data[63:0]); end
        issue_valid = 1; issue_wr = 1; issue_rd = 5'd2;
        step(); idle();
        #1;
        n_vec++; if (pending !== 32'h4) begin n_err++; $display("FAIL ar_post got %h want 4", pending); end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_x0();
        test_same_cycle();
        test_flush();
        test_wb_not_pending();
        test_reissue_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
